soc_decerr_slave: RTL and testbench

AXI4 error slave on the default port of the SoC crossbar. It terminates every transaction whose address falls outside the SoC address map, for example 0x0000_1000–0x0000_FFFF, 0x0400_0000–0x0BFF_FFFF, or anything at or above 0xC000_0000. Write data is drained and every access gets a DECERR response, so mis-addressed software traffic cannot hang the interconnect. It also records the first faulting address and counts faults for the debug and top-control logic.

---
 rtl/soc_decerr_slave_pkg.sv | 29 ++
 rtl/soc_decerr_slave.sv | 225 ++++++++++++++++++++++
 tb/tb_soc_decerr_slave.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/soc_decerr_slave_pkg.sv
// rtl/soc_decerr_slave_pkg.sv - shared SoC constants, response codes and error-slave FSM states
package soc_decerr_slave_pkg;

  // AXI response codes
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespDecErr = 2'b11;

  // Default read-data pattern returned by the error slave
  localparam logic [63:0] DefaultRdPattern = 64'hDEAD_BEEF_DEAD_BEEF;

  // SoC address map holes that route to the default (error) port
  localparam logic [63:0] HoleLoBase  = 64'h0000_0000_0000_1000;
  localparam logic [63:0] HoleLoTop   = 64'h0000_0000_0000_FFFF;
  localparam logic [63:0] HoleMidBase = 64'h0000_0000_0400_0000;
  localparam logic [63:0] HoleMidTop  = 64'h0000_0000_0BFF_FFFF;
  localparam logic [63:0] HoleHiBase  = 64'h0000_0000_C000_0000;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

endpackage

// File: rtl/soc_decerr_slave.sv
// rtl/soc_decerr_slave.sv - AXI4 default-port slave answering every access with DECERR and logging faults
module soc_decerr_slave
  import soc_decerr_slave_pkg::*;
#(
  parameter int unsigned             IdWidth   = 4,
  parameter int unsigned             AddrWidth = 64,
  parameter int unsigned             DataWidth = 64,
  parameter logic [DataWidth-1:0]    RdPattern = DataWidth'(DefaultRdPattern),
  parameter int unsigned             CntWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  // write address
  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  input  logic [IdWidth-1:0]   aw_id_i,
  input  logic [AddrWidth-1:0] aw_addr_i,
  // write data
  input  logic                 w_valid_i,
  output logic                 w_ready_o,
  input  logic                 w_last_i,
  // write response
  output logic                 b_valid_o,
  input  logic                 b_ready_i,
  output logic [IdWidth-1:0]   b_id_o,
  output logic [1:0]           b_resp_o,
  // read address
  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  input  logic [IdWidth-1:0]   ar_id_i,
  input  logic [AddrWidth-1:0] ar_addr_i,
  input  logic [7:0]           ar_len_i,
  // read data
  output logic                 r_valid_o,
  input  logic                 r_ready_i,
  output logic [IdWidth-1:0]   r_id_o,
  output logic [DataWidth-1:0] r_data_o,
  output logic [1:0]           r_resp_o,
  output logic                 r_last_o,
  // fault log
  output logic                 err_valid_o,
  output logic [AddrWidth-1:0] err_addr_o,
  output logic [CntWidth-1:0]  err_cnt_o,
  input  logic                 err_clr_i
);

  w_state_e             w_state_q, w_state_d;
  logic [IdWidth-1:0]   w_id_q, w_id_d;

  r_state_e             r_state_q, r_state_d;
  logic [IdWidth-1:0]   r_id_q, r_id_d;
  logic [7:0]           r_cnt_q, r_cnt_d;

  logic                 err_valid_q, err_valid_d;
  logic [AddrWidth-1:0] err_addr_q, err_addr_d;
  logic [CntWidth-1:0]  err_cnt_q, err_cnt_d;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign aw_hs = aw_valid_i & aw_ready_o;
  assign w_hs  = w_valid_i  & w_ready_o;
  assign b_hs  = b_valid_o  & b_ready_i;
  assign ar_hs = ar_valid_i & ar_ready_o;
  assign r_hs  = r_valid_o  & r_ready_i;

  // ---------------------------------------------------------------- write path

  // Write FSM state and latched AW ID
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
    end
  end

  // Write FSM next state: accept AW, drain beats until last, then hold B
  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          w_id_d    = aw_id_i;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (w_hs && w_last_i) begin
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (b_hs) begin
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write FSM outputs; readies are masked while reset is held so outputs read 0
  always_comb begin
    aw_ready_o = 1'b0;
    w_ready_o  = 1'b0;
    b_valid_o  = 1'b0;
    b_id_o     = '0;
    b_resp_o   = RespOkay;
    unique case (w_state_q)
      W_IDLE: aw_ready_o = ~rst_i;
      W_DATA: w_ready_o  = ~rst_i;
      W_RESP: begin
        b_valid_o = 1'b1;
        b_id_o    = w_id_q;
        b_resp_o  = RespDecErr;
      end
      default: ;
    endcase
  end

  // ----------------------------------------------------------------- read path

  // Read FSM state, latched AR ID and remaining-beat counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_cnt_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_cnt_q   <= r_cnt_d;
    end
  end

  // Read FSM next state: counter holds beats still to send after the current one
  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_cnt_d   = r_cnt_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          r_id_d    = ar_id_i;
          r_cnt_d   = ar_len_i;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (r_hs) begin
          if (r_cnt_q == 8'd0) begin
            r_state_d = R_IDLE;
          end else begin
            r_cnt_d = r_cnt_q - 8'd1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read FSM outputs; payload is zero whenever no beat is being offered
  always_comb begin
    ar_ready_o = 1'b0;
    r_valid_o  = 1'b0;
    r_id_o     = '0;
    r_data_o   = '0;
    r_resp_o   = RespOkay;
    r_last_o   = 1'b0;
    unique case (r_state_q)
      R_IDLE: ar_ready_o = ~rst_i;
      R_DATA: begin
        r_valid_o = 1'b1;
        r_id_o    = r_id_q;
        r_data_o  = RdPattern;
        r_resp_o  = RespDecErr;
        r_last_o  = (r_cnt_q == 8'd0);
      end
      default: ;
    endcase
  end

  // ----------------------------------------------------------------- fault log

  logic [1:0]          n_faults;
  logic [CntWidth:0]   err_sum;

  // Next fault-log value: saturating count, first address sticky, clear wins
  always_comb begin
    n_faults    = {1'b0, aw_hs} + {1'b0, ar_hs};
    err_sum     = {1'b0, err_cnt_q} + (CntWidth + 1)'(n_faults);
    err_valid_d = err_valid_q;
    err_addr_d  = err_addr_q;
    err_cnt_d   = err_sum[CntWidth] ? {CntWidth{1'b1}} : err_sum[CntWidth-1:0];
    if (!err_valid_q && (aw_hs || ar_hs)) begin
      err_valid_d = 1'b1;
      err_addr_d  = ar_hs ? ar_addr_i : aw_addr_i;
    end
    if (err_clr_i) begin
      err_valid_d = 1'b0;
      err_addr_d  = '0;
      err_cnt_d   = '0;
    end
  end

  // Fault-log registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      err_valid_q <= err_valid_d;
      err_addr_q  <= err_addr_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign err_valid_o = err_valid_q;
  assign err_addr_o  = err_addr_q;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_soc_decerr_slave.sv
// tb/tb_soc_decerr_slave.sv - scoreboard bench for the DECERR default slave
module tb_soc_decerr_slave;

  localparam int CW = 4;
  localparam logic [63:0] PAT = 64'hDEAD_BEEF_DEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        aw_valid = 0, w_valid = 0, w_last = 0, b_ready = 0;
  logic        ar_valid = 0, r_ready = 0, err_clr = 0;
  logic [3:0]  aw_id = 0, ar_id = 0;
  logic [63:0] aw_addr = 0, ar_addr = 0;
  logic [7:0]  ar_len = 0;
  logic        aw_ready, w_ready, b_valid, ar_ready, r_valid, r_last, err_valid;
  logic [3:0]  b_id, r_id;
  logic [1:0]  b_resp, r_resp;
  logic [63:0] r_data, err_addr;
  logic [CW-1:0] err_cnt;

  always #5 clk = ~clk;

  soc_decerr_slave #(.CntWidth(CW)) dut (
    .clk_i(clk), .rst_i(rst),
    .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_id_i(aw_id), .aw_addr_i(aw_addr),
    .w_valid_i(w_valid), .w_ready_o(w_ready), .w_last_i(w_last),
    .b_valid_o(b_valid), .b_ready_i(b_ready), .b_id_o(b_id), .b_resp_o(b_resp),
    .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_id_i(ar_id), .ar_addr_i(ar_addr),
    .ar_len_i(ar_len),
    .r_valid_o(r_valid), .r_ready_i(r_ready), .r_id_o(r_id), .r_data_o(r_data),
    .r_resp_o(r_resp), .r_last_o(r_last),
    .err_valid_o(err_valid), .err_addr_o(err_addr), .err_cnt_o(err_cnt), .err_clr_i(err_clr)
  );

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_beat_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_rsp_t;

  r_beat_t r_exp[$];
  b_rsp_t  b_exp[$];

  int checks = 0;
  int failures = 0;
  int w_beats = 0;
  int r_beats = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Monitors: sample at negedge, pop scoreboard on handshakes, check stall stability
  logic    r_stall = 0, b_stall = 0;
  r_beat_t r_hold;
  b_rsp_t  b_hold;

  always @(negedge clk) begin
    if (rst) begin
      r_stall = 0;
      b_stall = 0;
    end else begin
      if (w_valid && w_ready) w_beats++;
      if (r_stall) begin
        chk("r_stall_valid", {63'd0, r_valid}, 64'd1);
        chk("r_stall_payload", {51'd0, r_id, r_resp, r_last, 6'd0} ^ r_data,
            {51'd0, r_hold.id, r_hold.resp, r_hold.last, 6'd0} ^ r_hold.data);
      end
      if (b_stall) begin
        chk("b_stall_valid", {63'd0, b_valid}, 64'd1);
        chk("b_stall_payload", {58'd0, b_id, b_resp}, {58'd0, b_hold.id, b_hold.resp});
      end
      if (r_valid && r_ready) begin
        r_beat_t e;
        r_beats++;
        if (r_exp.size() == 0) chk("r_unexpected", 64'd1, 64'd0);
        else begin
          e = r_exp.pop_front();
          chk("r_id", {60'd0, r_id}, {60'd0, e.id});
          chk("r_data", r_data, e.data);
          chk("r_resp", {62'd0, r_resp}, {62'd0, e.resp});
          chk("r_last", {63'd0, r_last}, {63'd0, e.last});
        end
      end
      if (b_valid && b_ready) begin
        b_rsp_t e;
        if (b_exp.size() == 0) chk("b_unexpected", 64'd1, 64'd0);
        else begin
          e = b_exp.pop_front();
          chk("b_id", {60'd0, b_id}, {60'd0, e.id});
          chk("b_resp", {62'd0, b_resp}, {62'd0, e.resp});
        end
      end
      r_stall = r_valid && !r_ready;
      b_stall = b_valid && !b_ready;
      r_hold  = '{id: r_id, data: r_data, resp: r_resp, last: r_last};
      b_hold  = '{id: b_id, resp: b_resp};
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_aw(input logic [3:0] id, input logic [63:0] addr);
    int n = 0;
    aw_valid = 1; aw_id = id; aw_addr = addr;
    b_exp.push_back('{id: id, resp: 2'b11});
    @(negedge clk);
    while (!aw_ready && n < 100) begin n++; @(negedge clk); end
    if (n >= 100) chk("aw_timeout", 64'd0, 64'd1);
    step();
    aw_valid = 0;
  endtask

  task automatic do_ar(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len);
    int n = 0;
    ar_valid = 1; ar_id = id; ar_addr = addr; ar_len = len;
    for (int i = 0; i <= int'(len); i++)
      r_exp.push_back('{id: id, data: PAT, resp: 2'b11, last: (i == int'(len))});
    @(negedge clk);
    while (!ar_ready && n < 100) begin n++; @(negedge clk); end
    if (n >= 100) chk("ar_timeout", 64'd0, 64'd1);
    step();
    ar_valid = 0;
  endtask

  task automatic do_w(input int beats);
    for (int i = 0; i < beats; i++) begin
      int n = 0;
      w_valid = 1; w_last = (i == beats - 1);
      @(negedge clk);
      while (!w_ready && n < 100) begin n++; @(negedge clk); end
      if (n >= 100) chk("w_timeout", 64'd0, 64'd1);
      step();
    end
    w_valid = 0; w_last = 0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((r_exp.size() != 0 || b_exp.size() != 0) && n < 500) begin n++; step(); end
    if (n >= 500) chk(tag, 64'd0, 64'd1);
  endtask

  task automatic do_reset();
    rst = 1;
    r_exp.delete(); b_exp.delete();
    step(); step();
    rst = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    // reset state
    #2;
    chk("rst_aw_ready", {63'd0, aw_ready}, 64'd0);
    chk("rst_valids", {61'd0, b_valid, r_valid, err_valid}, 64'd0);
    step();
    rst = 0;
    @(negedge clk);
    chk("idle_readies", {62'd0, aw_ready, ar_ready}, 64'd3);
    chk("idle_log", {59'd0, err_valid, err_cnt}, 64'd0);
    chk("idle_w_ready", {63'd0, w_ready}, 64'd0);

    // write with 4 beats; W offered early must not be taken before AW
    step();
    w_valid = 1;
    @(negedge clk);
    chk("w_before_aw", {63'd0, w_ready}, 64'd0);
    step();
    w_valid = 0;
    do_aw(4'd3, 64'hC000_0000);
    @(negedge clk);
    chk("w_ready_after_aw", {63'd0, w_ready}, 64'd1);
    step();
    do_w(4);
    @(negedge clk);
    chk("b_valid_after_last", {63'd0, b_valid}, 64'd1);
    chk("w_beat_count", 64'(w_beats), 64'd4);
    step();
    b_ready = 1;
    drain("write1_drain");
    b_ready = 0;
    chk("log_addr_w", err_addr, 64'hC000_0000);
    chk("log_cnt_w", {60'd0, err_cnt}, 64'd1);

    // read of 8 beats with r_ready toggling
    base = r_beats;
    do_ar(4'd5, 64'h2000, 8'd7);
    @(negedge clk);
    chk("r_valid_after_ar", {63'd0, r_valid}, 64'd1);
    for (int c = 0; c < 100 && r_exp.size() != 0; c++) begin
      step();
      r_ready = (c % 3) != 1;
    end
    step();
    r_ready = 0;
    chk("read_beats", 64'(r_beats - base), 64'd8);
    chk("read_q_empty", 64'(r_exp.size()), 64'd0);
    @(negedge clk);
    chk("ar_ready_after_read", {63'd0, ar_ready}, 64'd1);
    chk("log_addr_sticky", err_addr, 64'hC000_0000);
    chk("log_cnt_r", {60'd0, err_cnt}, 64'd2);

    // simultaneous AW and AR from reset
    do_reset();
    aw_valid = 1; aw_id = 4'd1; aw_addr = 64'h0400_0000;
    ar_valid = 1; ar_id = 4'd2; ar_addr = 64'h0800_0000; ar_len = 8'd0;
    b_exp.push_back('{id: 4'd1, resp: 2'b11});
    r_exp.push_back('{id: 4'd2, data: PAT, resp: 2'b11, last: 1'b1});
    @(negedge clk);
    chk("sim_readies", {62'd0, aw_ready, ar_ready}, 64'd3);
    step();
    aw_valid = 0; ar_valid = 0;
    @(negedge clk);
    chk("sim_addr", err_addr, 64'h0800_0000);
    chk("sim_cnt", {60'd0, err_cnt}, 64'd2);
    step();
    r_ready = 1; b_ready = 1;
    do_w(1);
    drain("sim_drain");
    r_ready = 0; b_ready = 0;

    // B back-pressure for 10 cycles, then back-to-back AW
    do_aw(4'd6, 64'h1000);
    do_w(1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_b_valid", {63'd0, b_valid}, 64'd1);
      chk("bp_aw_ready", {63'd0, aw_ready}, 64'd0);
      step();
    end
    b_ready = 1;
    aw_valid = 1; aw_id = 4'd7; aw_addr = 64'h1_0000_0000;
    b_exp.push_back('{id: 4'd7, resp: 2'b11});
    @(negedge clk);
    chk("bp_aw_in_b_cycle", {63'd0, aw_ready}, 64'd0);
    step();
    @(negedge clk);
    chk("bp_aw_after_b", {63'd0, aw_ready}, 64'd1);
    step();
    aw_valid = 0;
    do_w(2);
    drain("bp_drain");
    b_ready = 0;

    // saturation at 15 and clear together with an AR
    do_reset();
    r_ready = 1;
    for (int i = 0; i < 20; i++) do_ar(4'(i), 64'h1_0000 + 64'(i * 16), 8'd0);
    drain("sat_drain");
    @(negedge clk);
    chk("sat_cnt", {60'd0, err_cnt}, 64'd15);
    chk("sat_first_addr", err_addr, 64'h1_0000);
    step();
    ar_valid = 1; ar_id = 4'd9; ar_addr = 64'hF000_0000; ar_len = 8'd0; err_clr = 1;
    r_exp.push_back('{id: 4'd9, data: PAT, resp: 2'b11, last: 1'b1});
    @(negedge clk);
    chk("clr_ar_ready", {63'd0, ar_ready}, 64'd1);
    step();
    ar_valid = 0; err_clr = 0;
    @(negedge clk);
    chk("clr_log", {59'd0, err_valid, err_cnt}, 64'd0);
    chk("clr_addr", err_addr, 64'd0);
    drain("clr_drain");

    // reset in the middle of an 8-beat read
    base = r_beats;
    do_ar(4'd4, 64'h3000, 8'd7);
    for (int c = 0; c < 100 && r_beats < base + 2; c++) step();
    chk("mid_beats", 64'(r_beats - base), 64'd2);
    rst = 1;
    #1;
    chk("mid_rst_valids", {62'd0, r_valid, b_valid}, 64'd0);
    r_exp.delete();
    step();
    rst = 0;
    r_ready = 0;
    @(negedge clk);
    chk("mid_ar_ready", {63'd0, ar_ready}, 64'd1);
    chk("mid_err_valid", {63'd0, err_valid}, 64'd0);
    chk("mid_r_valid", {63'd0, r_valid}, 64'd0);
    step();

    chk("final_queues", 64'(r_exp.size() + b_exp.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
